vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Upstream pixel-timing stage for the VGA video path. Generates 640x480@60 Hz raster counters DrawX/DrawY and the active-video flag `blank` (1 = visible pixel) that feed the sprite/background renderers. Produces the monitor hs/vs strobes delayed by a parameterised number of cycles, so they stay aligned with the renderers' registered colour outputs. Also emits a one-cycle frame_start pulse for game-state update logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_DELAY, 2, pipeline stages on hs/vs (0..7); matches the renderer ROM read (1 stage) plus the colour register (1 stage)

Ports:
vga_clk  input  1  25 MHz pixel clock; all logic on the rising edge
reset_n  input  1  synchronous, active-low reset
DrawX  output  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters = 800)
DrawY  output  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = sum of the V_* parameters = 525)
blank  output  1  1 when DrawX<H_ACTIVE and DrawY<V_ACTIVE and running; aligned with DrawX/DrawY
hs  output  1  active-low horizontal sync, delayed SYNC_DELAY cycles
vs  output  1  active-low vertical sync, delayed SYNC_DELAY cycles
frame_start  output  1  one-cycle pulse when DrawX=0, DrawY=0 and running; aligned with DrawX/DrawY

Behaviour:
- State registers:
  - hc, vc (10 b each); DrawX=hc, DrawY=vc directly, with no added latency.
  - running (1 b).
  - hs_pipe, vs_pipe: SYNC_DELAY-deep shift registers.
- Reset (reset_n=0 at a rising edge):
  - hc<=0, vc<=0, running<=0.
  - All hs_pipe/vs_pipe stages <=1.
  - Resulting outputs: DrawX=0, DrawY=0, blank=0, frame_start=0, hs=1, vs=1.
  - Reset applied mid-frame or mid-sync takes effect at that edge and aborts the frame; no partial-line completion.
- Start-up:
  - First edge with reset_n=1: running<=1; counters hold at 0.
  - Following cycle: blank=1, frame_start=1 at (0,0).
  - Counting begins on the next edge.
- Counting (running=1, each edge):
  - If hc==H_TOTAL-1: hc<=0, and vc<=(vc==V_TOTAL-1)?0:vc+1.
  - Else: hc<=hc+1.
  - vc changes only at the hc wrap. Wrap values: 799->0 horizontally, 524->0 vertically.
  - The (799,524)->(0,0) transition gives frame_start=1 for exactly one cycle.
- Sync decode (undelayed):
  - hs_raw=0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw=0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491, for every hc on those lines.
  - hs_raw and vs_raw are forced to 1 while running=0.
- Sync delay:
  - hs = hs_raw after exactly SYNC_DELAY edges; vs likewise.
  - SYNC_DELAY=0: hs/vs are combinational decodes of the current counters.
- Blanking: blank is 0 for hc in 640..799 or vc in 480..524. It is never delayed; downstream renderers register it with their colour.
- Widths: all comparisons are unsigned on 10 b. H_TOTAL and V_TOTAL must be <=1024 (elaboration-time assertion).
- Per-frame counts:
  - blank=1 for exactly 307200 cycles per frame.
  - hs has 525 low pulses per frame, each 96 cycles wide.
  - vs has one low pulse per frame, 1600 cycles wide.
  - Frame period is 420000 cycles.

Test Plan:
- Hold reset_n=0 for 5 cycles, release -> during reset DrawX=0, DrawY=0, blank=0, hs=vs=1. Cycle 1 after release: blank=1, frame_start=1. Cycle 2: DrawX=1, frame_start=0.
- Run one full line from (0,0) -> blank falls when DrawX goes 639->640. hs_raw low on DrawX 656..751; hs low on DrawX 658..753 (SYNC_DELAY=2). DrawX 799->0 with DrawY 0->1.
- Run to line 489/490 -> vs goes low 2 cycles after (0,490) and goes high 2 cycles after (0,492). blank stays 0 for DrawY 480..524.
- Run 2 full frames -> frame_start interval exactly 420000 cycles. Count of blank=1 per frame is 307200. DrawY never exceeds 524; DrawX never exceeds 799.
- Assert reset_n=0 for one edge at (700,491), mid hs and vs -> next cycle DrawX=0, DrawY=0, hs=vs=1, blank=0. Restart sequence identical to the first scenario.
- Elaborate with SYNC_DELAY=0 -> hs low exactly on DrawX 656..751 in the same cycle; all other behaviour unchanged.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster position, blanking and sync outputs of the VGA timing generator
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       frame_start;
    modport master (output DrawX, DrawY, blank, hs, vs, frame_start);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, blanking, frame pulse and delayed hs/vs for the VGA path
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_LO  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_HI  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_LO  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_HI  = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be in 0..7");
    end

    logic [9:0]  hc_q, hc_d, vc_q, vc_d;
    logic        running_q;
    logic [10:0] hx, vx;
    logic        hs_raw, vs_raw;

    assign hx = {1'b0, hc_q};
    assign vx = {1'b0, vc_q};

    // Raster scan: counters hold until running, then wrap per line and per frame
    always_comb begin
        hc_d = !running_q ? hc_q : (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
        vc_d = (!running_q || hc_q != H_LAST) ? vc_q : (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
    end

    // Counter and run-flag registers; reset aborts the frame at the same edge
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q      <= '0;
            vc_q      <= '0;
            running_q <= 1'b0;
        end else begin
            hc_q      <= hc_d;
            vc_q      <= vc_d;
            running_q <= 1'b1;
        end
    end

    // Sync windows are held inactive until the raster is running
    assign hs_raw = !(running_q && hx >= HS_LO && hx < HS_HI);
    assign vs_raw = !(running_q && vx >= VS_LO && vx < VS_HI);

    assign vga_o.DrawX       = hc_q;
    assign vga_o.DrawY       = vc_q;
    assign vga_o.blank       = running_q && hx < H_VIS && vx < V_VIS;
    assign vga_o.frame_start = running_q && hc_q == 10'd0 && vc_q == 10'd0;

    if (SYNC_DELAY == 0) begin : g_nodelay
        assign vga_o.hs = hs_raw;
        assign vga_o.vs = vs_raw;
    end else begin : g_delay
        logic [SYNC_DELAY-1:0] hs_pipe_q, vs_pipe_q, hs_pipe_d, vs_pipe_d;
        assign hs_pipe_d = SYNC_DELAY'({hs_pipe_q, hs_raw});
        assign vs_pipe_d = SYNC_DELAY'({vs_pipe_q, vs_raw});
        // Sync delay line keeps hs/vs aligned with the renderers' registered colour
        always_ff @(posedge vga_clk) begin
            if (!reset_n) begin
                hs_pipe_q <= '1;
                vs_pipe_q <= '1;
            end else begin
                hs_pipe_q <= hs_pipe_d;
                vs_pipe_q <= vs_pipe_d;
            end
        end
        assign vga_o.hs = hs_pipe_q[SYNC_DELAY-1];
        assign vga_o.vs = vs_pipe_q[SYNC_DELAY-1];
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks full-size and reduced-size timing generators against an arithmetic raster model
module tb_vga_timing_gen;
    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int d;
    } cfg_t;

    localparam cfg_t CA = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    localparam cfg_t CB = '{16, 2, 4, 3, 12, 2, 2, 3, 0};
    localparam cfg_t CC = '{16, 2, 4, 3, 12, 2, 2, 3, 3};

    logic vga_clk;
    logic ra_n, rb_n;
    int   na = -1, nb = -1;
    int   n_cmp = 0, n_bad = 0, frames = 0;
    int   m_cyc, m_blk, m_hsp, m_hrun, m_vrun;
    bit   m_fv;

    vga_timing_gen_if ia();
    vga_timing_gen_if ib();
    vga_timing_gen_if ic();

    vga_timing_gen #(.SYNC_DELAY(2)) dut_a (.vga_clk(vga_clk), .reset_n(ra_n), .vga_o(ia));
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .SYNC_DELAY(0)) dut_b (.vga_clk(vga_clk), .reset_n(rb_n), .vga_o(ib));
    vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3), .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .SYNC_DELAY(3)) dut_c (.vga_clk(vga_clk), .reset_n(rb_n), .vga_o(ic));

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    // Model state: edges seen with reset released since the last reset edge (-1 = never reset)
    always @(posedge vga_clk) begin
        na <= !ra_n ? 0 : (na < 0 ? -1 : na + 1);
        nb <= !rb_n ? 0 : (nb < 0 ? -1 : nb + 1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit sync_raw(input cfg_t c, input int n, input bit horiz);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        int p = n - 1;
        int x, y;
        if (n < 1) return 1'b1;
        x = p % ht;
        y = (p / ht) % vt;
        return horiz ? !(x >= c.ha + c.hf && x < c.ha + c.hf + c.hs)
                     : !(y >= c.va + c.vf && y < c.va + c.vf + c.vs);
    endfunction

    task automatic cmp_dut(input string t, input cfg_t c, input int n, input logic [9:0] x, input logic [9:0] y,
                           input logic b, input logic h, input logic v, input logic f);
        int ht = c.ha + c.hf + c.hs + c.hb;
        int vt = c.va + c.vf + c.vs + c.vb;
        int p = n > 0 ? n - 1 : 0;
        int ex = p % ht;
        int ey = (p / ht) % vt;
        chk({t, " DrawX"}, x, ex);
        chk({t, " DrawY"}, y, ey);
        chk({t, " blank"}, b, n > 0 && ex < c.ha && ey < c.va);
        chk({t, " frame_start"}, f, n > 0 && p % (ht * vt) == 0);
        chk({t, " hs"}, h, sync_raw(c, n - c.d, 1'b1));
        chk({t, " vs"}, v, sync_raw(c, n - c.d, 1'b0));
    endtask

    // Every-cycle comparison of all three instances against the model
    initial forever begin
        @(negedge vga_clk);
        if (na >= 0) cmp_dut("A", CA, na, ia.DrawX, ia.DrawY, ia.blank, ia.hs, ia.vs, ia.frame_start);
        if (nb >= 0) cmp_dut("B", CB, nb, ib.DrawX, ib.DrawY, ib.blank, ib.hs, ib.vs, ib.frame_start);
        if (nb >= 0) cmp_dut("C", CC, nb, ic.DrawX, ic.DrawY, ic.blank, ic.hs, ic.vs, ic.frame_start);
    end

    // Per-frame totals on the reduced raster: 25x19 = 475 cycles, 16x12 = 192 visible, 19 hs pulses of 4, vs of 2 lines
    initial forever begin
        @(negedge vga_clk);
        if (nb <= 0) begin
            m_fv = 0; m_hrun = 0; m_vrun = 0;
        end else begin
            if (ib.frame_start) begin
                if (m_fv) begin
                    chk("B frame period", m_cyc, 475);
                    chk("B blank per frame", m_blk, 192);
                    chk("B hs pulses per frame", m_hsp, 19);
                    frames++;
                end
                m_fv = 1; m_cyc = 0; m_blk = 0; m_hsp = 0;
            end
            m_cyc++;
            m_blk += int'(ib.blank);
            if (!ib.hs) m_hrun++;
            else begin
                if (m_hrun > 0) begin
                    chk("B hs width", m_hrun, 4);
                    m_hsp++;
                end
                m_hrun = 0;
            end
            if (!ic.vs) m_vrun++;
            else begin
                if (m_vrun > 0) chk("C vs width", m_vrun, 50);
                m_vrun = 0;
            end
        end
    end

    task automatic tick();
        @(negedge vga_clk);
    endtask

    function automatic int gx(input int w);
        return w == 0 ? int'(ia.DrawX) : w == 1 ? int'(ib.DrawX) : int'(ic.DrawX);
    endfunction

    function automatic int gy(input int w);
        return w == 0 ? int'(ia.DrawY) : w == 1 ? int'(ib.DrawY) : int'(ic.DrawY);
    endfunction

    task automatic wait_pos(input int w, input int x, input int y, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (gx(w) == x && gy(w) == y) break;
            tick();
        end
        chk($sformatf("reach dut%0d (%0d,%0d)", w, x, y), i < budget, 1);
    endtask

    initial begin
        ra_n = 1'b0;
        rb_n = 1'b0;
        repeat (5) tick();
        chk("A reset DrawX", ia.DrawX, 0);
        chk("A reset DrawY", ia.DrawY, 0);
        chk("A reset blank", ia.blank, 0);
        chk("A reset hs", ia.hs, 1);
        chk("A reset vs", ia.vs, 1);
        chk("A reset frame_start", ia.frame_start, 0);
        ra_n = 1'b1;
        rb_n = 1'b1;
        tick();
        chk("A start blank", ia.blank, 1);
        chk("A start frame_start", ia.frame_start, 1);
        chk("A start DrawX", ia.DrawX, 0);
        tick();
        chk("A second DrawX", ia.DrawX, 1);
        chk("A second frame_start", ia.frame_start, 0);
        wait_pos(0, 639, 0, 800);
        chk("A blank at 639", ia.blank, 1);
        tick();
        chk("A DrawX 640", ia.DrawX, 640);
        chk("A blank at 640", ia.blank, 0);
        wait_pos(0, 657, 0, 100);
        chk("A hs at 657", ia.hs, 1);
        tick();
        chk("A hs at 658", ia.hs, 0);
        wait_pos(0, 753, 0, 200);
        chk("A hs at 753", ia.hs, 0);
        tick();
        chk("A hs at 754", ia.hs, 1);
        wait_pos(0, 799, 0, 100);
        tick();
        chk("A wrap DrawX", ia.DrawX, 0);
        chk("A wrap DrawY", ia.DrawY, 1);

        wait_pos(1, 20, 15, 600);
        chk("B hs mid sync", ib.hs, 0);
        chk("B vs mid sync", ib.vs, 0);
        rb_n = 1'b0;
        tick();
        rb_n = 1'b1;
        chk("B abort DrawX", ib.DrawX, 0);
        chk("B abort DrawY", ib.DrawY, 0);
        chk("B abort blank", ib.blank, 0);
        chk("B abort hs", ib.hs, 1);
        chk("B abort vs", ib.vs, 1);
        chk("C abort hs", ic.hs, 1);
        chk("C abort vs", ic.vs, 1);
        tick();
        chk("B restart blank", ib.blank, 1);
        chk("B restart frame_start", ib.frame_start, 1);
        tick();
        chk("B restart DrawX", ib.DrawX, 1);
        chk("B restart frame_start low", ib.frame_start, 0);
        wait_pos(1, 17, 0, 50);
        chk("B hs at 17", ib.hs, 1);
        tick();
        chk("B hs at 18", ib.hs, 0);
        wait_pos(1, 21, 0, 10);
        chk("B hs at 21", ib.hs, 0);
        tick();
        chk("B hs at 22", ib.hs, 1);
        wait_pos(2, 0, 14, 500);
        chk("C vs at line 14 +0", ic.vs, 1);
        tick();
        chk("C vs at line 14 +1", ic.vs, 1);
        tick();
        chk("C vs at line 14 +2", ic.vs, 1);
        tick();
        chk("C vs at line 14 +3", ic.vs, 0);

        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(60, 1500)) tick();
            if ($urandom_range(0, 1) == 1) begin
                rb_n = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                rb_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                ra_n = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                ra_n = 1'b1;
            end
        end
        repeat (10) tick();
        chk("B frames measured", frames >= 2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
